// File: rtl/ddf_acc_arbiter_2ch.sv
// Round-robin scheduler that lends one NDA-driven DDF accumulator to two channels,
// serialising whole bursts: token offer, data routing, result return.
module ddf_acc_arbiter_2ch #(
  parameter int WIDTH     = 32,
  parameter int WIDTH_NDA = 4
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 ch0_len_empty,
  input  logic [WIDTH_NDA-1:0] ch0_len_data,
  output logic                 ch0_len_rd,
  input  logic                 ch0_in_empty,
  input  logic [WIDTH-1:0]     ch0_in_data,
  output logic                 ch0_in_rd,
  input  logic                 ch0_out_full,
  output logic                 ch0_out_wr,
  output logic [WIDTH-1:0]     ch0_out_data,
  input  logic                 ch1_len_empty,
  input  logic [WIDTH_NDA-1:0] ch1_len_data,
  output logic                 ch1_len_rd,
  input  logic                 ch1_in_empty,
  input  logic [WIDTH-1:0]     ch1_in_data,
  output logic                 ch1_in_rd,
  input  logic                 ch1_out_full,
  output logic                 ch1_out_wr,
  output logic [WIDTH-1:0]     ch1_out_data,
  output logic                 acc_nda_empty,
  output logic [WIDTH_NDA-1:0] acc_nda_data,
  input  logic                 acc_nda_rd,
  output logic                 acc_in0_empty,
  output logic [WIDTH-1:0]     acc_in0_data,
  input  logic                 acc_in0_rd,
  output logic                 acc_out0_full,
  input  logic                 acc_out0_wr,
  input  logic [WIDTH-1:0]     acc_out0_data,
  output logic [1:0]           gnt,
  output logic [1:0]           done,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

  state_t               state_q, state_d;
  logic                 sel_q, sel_d;
  logic                 ptr_q, ptr_d;
  logic [1:0]           gnt_q, gnt_d;
  logic [1:0]           len_rd_q, len_rd_d;
  logic [1:0]           done_q, done_d;
  logic [WIDTH_NDA-1:0] tok_q, tok_d;
  logic [WIDTH_NDA-1:0] rdc_q, rdc_d;
  logic                 err_q, err_d;
  logic [1:0]           len_pend;
  logic                 pick;
  logic                 busy;

  assign len_pend = {~ch1_len_empty, ~ch0_len_empty};
  assign busy     = (state_q == BUSY);

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      ptr_q    <= 1'b0;
      gnt_q    <= 2'b00;
      len_rd_q <= 2'b00;
      done_q   <= 2'b00;
      tok_q    <= '0;
      rdc_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      len_rd_q <= len_rd_d;
      done_q   <= done_d;
      tok_q    <= tok_d;
      rdc_q    <= rdc_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    len_rd_d = 2'b00;
    done_d   = 2'b00;
    tok_d    = tok_q;
    rdc_d    = rdc_q;
    err_d    = err_q;
    // ptr_q names the channel that wins a tie; it points away from the last one served
    pick     = (len_pend == 2'b11) ? ptr_q : len_pend[1];

    case (state_q)
      IDLE: begin
        if (|len_pend) begin
          sel_d    = pick;
          gnt_d    = pick ? 2'b10 : 2'b01;
          len_rd_d = pick ? 2'b10 : 2'b01;
          tok_d    = pick ? ch1_len_data : ch0_len_data;
          rdc_d    = '0;
          state_d  = OFFER;
        end
      end
      OFFER: begin
        if (acc_nda_rd) begin
          if (tok_q == '0) begin
            // zero-length bursts count as served so they cannot starve the other channel
            done_d  = gnt_q;
            gnt_d   = 2'b00;
            ptr_d   = ~sel_q;
            state_d = IDLE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (acc_in0_rd) rdc_d = rdc_q + WIDTH_NDA'(1);
        if (acc_out0_wr) begin
          done_d  = gnt_q;
          gnt_d   = 2'b00;
          ptr_d   = ~sel_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!busy && (acc_in0_rd || acc_out0_wr)) err_d = 1'b1;
    if ((state_q != OFFER) && acc_nda_rd) err_d = 1'b1;
    if (busy && acc_in0_rd && (rdc_q == tok_q)) err_d = 1'b1;
  end

  assign ch0_len_rd    = len_rd_q[0];
  assign ch1_len_rd    = len_rd_q[1];
  assign gnt           = gnt_q;
  assign done          = done_q;
  assign err           = err_q;
  assign acc_nda_empty = (state_q != OFFER);
  assign acc_nda_data  = tok_q;

  // in0/out0 are routed combinationally so the actor's handshake sees no extra latency
  assign acc_in0_empty = busy ? (sel_q ? ch1_in_empty : ch0_in_empty) : 1'b1;
  assign acc_in0_data  = sel_q ? ch1_in_data : ch0_in_data;
  assign acc_out0_full = busy ? (sel_q ? ch1_out_full : ch0_out_full) : 1'b1;
  assign ch0_in_rd     = busy && !sel_q && acc_in0_rd;
  assign ch1_in_rd     = busy &&  sel_q && acc_in0_rd;
  assign ch0_out_wr    = busy && !sel_q && acc_out0_wr;
  assign ch1_out_wr    = busy &&  sel_q && acc_out0_wr;
  assign ch0_out_data  = acc_out0_data;
  assign ch1_out_data  = acc_out0_data;

endmodule

// File: tb/tb_ddf_acc_arbiter_2ch.sv
// Bench for ddf_acc_arbiter_2ch: FWFT channel FIFO models, a behavioural accumulator
// actor, and a scoreboard of expected per-channel results.
`timescale 1ns/1ps
module tb_ddf_acc_arbiter_2ch;
  localparam int W  = 32;
  localparam int WN = 4;

  typedef struct {
    int         ch;
    logic [W-1:0] val;
  } sb_t;

  logic ck = 1'b0;
  logic rst = 1'b0;
  always #5 ck = ~ck;

  logic [1:0]    len_empty = 2'b11;
  logic [1:0]    in_empty  = 2'b11;
  logic [1:0]    out_full  = 2'b00;
  logic [1:0]    stall     = 2'b00;
  logic [WN-1:0] len_data [2];
  logic [W-1:0]  in_data  [2];
  logic [W-1:0]  out_data [2];
  logic [1:0]    len_rd, in_rd, out_wr, gnt, done;
  logic          err;
  logic          acc_nda_empty, acc_in0_empty, acc_out0_full;
  logic [WN-1:0] acc_nda_data;
  logic [W-1:0]  acc_in0_data;
  logic          acc_nda_rd    = 1'b0;
  logic          a_in0_rd      = 1'b0;
  logic          force_in0_rd  = 1'b0;
  logic          acc_in0_rd;
  logic          acc_out0_wr   = 1'b0;
  logic [W-1:0]  acc_out0_data = '0;
  assign acc_in0_rd = a_in0_rd | force_in0_rd;

  ddf_acc_arbiter_2ch #(.WIDTH(W), .WIDTH_NDA(WN)) dut (
    .ck(ck), .rst(rst),
    .ch0_len_empty(len_empty[0]), .ch0_len_data(len_data[0]), .ch0_len_rd(len_rd[0]),
    .ch0_in_empty(in_empty[0]), .ch0_in_data(in_data[0]), .ch0_in_rd(in_rd[0]),
    .ch0_out_full(out_full[0]), .ch0_out_wr(out_wr[0]), .ch0_out_data(out_data[0]),
    .ch1_len_empty(len_empty[1]), .ch1_len_data(len_data[1]), .ch1_len_rd(len_rd[1]),
    .ch1_in_empty(in_empty[1]), .ch1_in_data(in_data[1]), .ch1_in_rd(in_rd[1]),
    .ch1_out_full(out_full[1]), .ch1_out_wr(out_wr[1]), .ch1_out_data(out_data[1]),
    .acc_nda_empty(acc_nda_empty), .acc_nda_data(acc_nda_data), .acc_nda_rd(acc_nda_rd),
    .acc_in0_empty(acc_in0_empty), .acc_in0_data(acc_in0_data), .acc_in0_rd(acc_in0_rd),
    .acc_out0_full(acc_out0_full), .acc_out0_wr(acc_out0_wr), .acc_out0_data(acc_out0_data),
    .gnt(gnt), .done(done), .err(err)
  );

  int checks = 0;
  int failures = 0;

  // channel FIFO contents; flags refresh 1 ns after each rising edge
  logic [WN-1:0] lenq0[$], lenq1[$];
  logic [W-1:0]  datq0[$], datq1[$];
  logic [1:0]    pop_len = 2'b00;
  logic [1:0]    pop_in  = 2'b00;

  always @(negedge ck) begin
    pop_len = len_rd;
    pop_in  = in_rd;
  end

  always @(posedge ck) begin
    #1;
    if (pop_len[0] && lenq0.size() > 0) void'(lenq0.pop_front());
    if (pop_len[1] && lenq1.size() > 0) void'(lenq1.pop_front());
    if (pop_in[0] && datq0.size() > 0) void'(datq0.pop_front());
    if (pop_in[1] && datq1.size() > 0) void'(datq1.pop_front());
    len_empty[0] = (lenq0.size() == 0);
    len_empty[1] = (lenq1.size() == 0);
    len_data[0]  = (lenq0.size() > 0) ? lenq0[0] : '0;
    len_data[1]  = (lenq1.size() > 0) ? lenq1[0] : '0;
    in_empty[0]  = (datq0.size() == 0) || stall[0];
    in_empty[1]  = (datq1.size() == 0) || stall[1];
    in_data[0]   = (datq0.size() > 0) ? datq0[0] : '0;
    in_data[1]   = (datq1.size() > 0) ? datq1[0] : '0;
  end

  // accumulator actor: take a length token, sum that many words, emit one result
  int            a_state = 0;
  logic [WN-1:0] a_n = '0;
  logic [WN-1:0] a_cnt = '0;
  logic [W-1:0]  a_sum = '0;

  always @(posedge ck) begin
    #2;
    acc_nda_rd  = 1'b0;
    a_in0_rd    = 1'b0;
    acc_out0_wr = 1'b0;
    if (!rst) begin
      a_state = 0;
    end else begin
      case (a_state)
        0: if (!acc_nda_empty) begin
          acc_nda_rd = 1'b1;
          a_n = acc_nda_data; a_cnt = '0; a_sum = '0;
          a_state = (acc_nda_data == '0) ? 0 : 1;
        end
        1: if (!acc_in0_empty) begin
          a_in0_rd = 1'b1;
          a_sum = a_sum + acc_in0_data;
          a_cnt = a_cnt + 1'b1;
          if (a_cnt == a_n) a_state = 2;
        end
        default: begin
          acc_out0_data = a_sum;
          if (!acc_out0_full) begin
            acc_out0_wr = 1'b1;
            a_state = 0;
          end
        end
      endcase
    end
  end

  // monitor: observed results and activity counters
  int  cyc = 0;
  int  wr_cnt[2], in_rd_cnt[2], len_rd_cnt[2], done_cnt[2];
  int  viol = 0;
  int  last_wr_cyc = -1;
  int  gaps[$];
  sb_t obs_q[$];
  sb_t exp_q[$];

  initial for (int c = 0; c < 2; c++) begin
    wr_cnt[c] = 0; in_rd_cnt[c] = 0; len_rd_cnt[c] = 0; done_cnt[c] = 0;
  end

  always @(posedge ck) cyc++;

  always @(negedge ck) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        if (out_wr[c]) begin
          obs_q.push_back('{c, out_data[c]});
          wr_cnt[c]++;
          last_wr_cyc = cyc;
        end
        if (in_rd[c]) in_rd_cnt[c]++;
        if (len_rd[c]) begin
          len_rd_cnt[c]++;
          if (last_wr_cyc >= 0) gaps.push_back(cyc - last_wr_cyc);
        end
        if (done[c]) done_cnt[c]++;
        if ((len_rd[c] || in_rd[c] || out_wr[c]) && !gnt[c]) viol++;
      end
    end
  end

  task automatic push_len(input int ch, input logic [WN-1:0] n);
    if (ch == 0) lenq0.push_back(n); else lenq1.push_back(n);
  endtask

  task automatic push_dat(input int ch, input logic [W-1:0] v);
    if (ch == 0) datq0.push_back(v); else datq1.push_back(v);
  endtask

  task automatic push_exp(input int ch, input logic [W-1:0] v);
    exp_q.push_back('{ch, v});
  endtask

  task automatic score(input string name);
    sb_t o, e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s unexpected write ch%0d data=%0d required=no write", name, o.ch, o.val);
      end else begin
        e = exp_q.pop_front();
        if (o.ch != e.ch || o.val !== e.val) begin
          failures++;
          $display("FAIL %s result got ch%0d=%0d required ch%0d=%0d", name, o.ch, o.val, e.ch, e.val);
        end else begin
          $display("result %s ch%0d=%0d", name, o.ch, o.val);
        end
      end
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (n < budget && !(exp_q.size() == 0 && gnt == 2'b00 && acc_nda_empty &&
                           lenq0.size() == 0 && lenq1.size() == 0)) begin
      @(negedge ck);
      score(name);
      n++;
    end
    if (n >= budget) begin
      checks++; failures++;
      $display("FAIL %s timeout pending_results=%0d required=0", name, exp_q.size());
    end
    repeat (3) begin
      @(negedge ck);
      score(name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge ck);
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b required=00", gnt); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b required=00", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b required=0", err); end
    checks++; if ({len_rd, in_rd, out_wr} !== 6'b0) begin
      failures++; $display("FAIL reset_rdwr got=%b required=000000", {len_rd, in_rd, out_wr});
    end
    checks++; if ({acc_nda_empty, acc_in0_empty, acc_out0_full} !== 3'b111) begin
      failures++; $display("FAIL reset_empty_full got=%b required=111", {acc_nda_empty, acc_in0_empty, acc_out0_full});
    end
    $display("reset checked");
    rst = 1'b1;
    repeat (2) @(negedge ck);
  endtask

  task automatic test_alternate();
    int base_gaps = gaps.size();
    int d0 = done_cnt[0];
    int d1 = done_cnt[1];
    int bad = 0;
    int n;
    for (int k = 0; k < 2; k++) begin
      push_len(0, 4'd2); push_len(1, 4'd2);
    end
    for (int k = 0; k < 4; k++) begin
      push_dat(0, 32'd1); push_dat(1, 32'd1);
    end
    for (int k = 0; k < 4; k++) push_exp(k % 2, 32'd2);
    wait_drain("alternate", 200);
    n = gaps.size() - base_gaps;
    if (n < 3) bad = 1;
    else for (int k = gaps.size() - 3; k < gaps.size(); k++) if (gaps[k] != 2) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL alternate_gap bad_gaps=%0d required=0 (write to next grant = 2 cycles)", bad); end
    checks++; if (done_cnt[0] - d0 != 2 || done_cnt[1] - d1 != 2) begin
      failures++; $display("FAIL alternate_done got=%0d,%0d required=2,2", done_cnt[0] - d0, done_cnt[1] - d1);
    end
  endtask

  task automatic test_single();
    int d0 = done_cnt[0];
    int r0 = in_rd_cnt[0];
    int act1 = in_rd_cnt[1] + wr_cnt[1] + len_rd_cnt[1];
    push_len(0, 4'd3);
    push_dat(0, 32'd1); push_dat(0, 32'd2); push_dat(0, 32'd3);
    push_exp(0, 32'd6);
    wait_drain("single", 100);
    checks++; if (done_cnt[0] - d0 != 1) begin failures++; $display("FAIL single_done got=%0d required=1", done_cnt[0] - d0); end
    checks++; if (in_rd_cnt[0] - r0 != 3) begin failures++; $display("FAIL single_reads got=%0d required=3", in_rd_cnt[0] - r0); end
    checks++; if (in_rd_cnt[1] + wr_cnt[1] + len_rd_cnt[1] != act1) begin
      failures++; $display("FAIL single_ch1_quiet got=%0d required=0", in_rd_cnt[1] + wr_cnt[1] + len_rd_cnt[1] - act1);
    end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b required=0", err); end
  endtask

  task automatic test_zero_len();
    int d1 = done_cnt[1];
    int l1 = len_rd_cnt[1];
    int r1 = in_rd_cnt[1];
    int w1 = wr_cnt[1];
    push_len(1, 4'd0); push_len(1, 4'd2);
    push_dat(1, 32'd5); push_dat(1, 32'd7);
    push_exp(1, 32'd12);
    wait_drain("zero_len", 100);
    checks++; if (done_cnt[1] - d1 != 2) begin failures++; $display("FAIL zero_done got=%0d required=2", done_cnt[1] - d1); end
    checks++; if (len_rd_cnt[1] - l1 != 2) begin failures++; $display("FAIL zero_len_rd got=%0d required=2", len_rd_cnt[1] - l1); end
    checks++; if (in_rd_cnt[1] - r1 != 2 || wr_cnt[1] - w1 != 1) begin
      failures++; $display("FAIL zero_rdwr got reads=%0d writes=%0d required reads=2 writes=1", in_rd_cnt[1] - r1, wr_cnt[1] - w1);
    end
  endtask

  task automatic test_out_full();
    int r0 = in_rd_cnt[0];
    int n = 0;
    out_full[0] = 1'b1;
    push_len(0, 4'd2);
    push_dat(0, 32'd4); push_dat(0, 32'd9);
    push_exp(0, 32'd13);
    while (n < 40 && in_rd_cnt[0] - r0 < 2) begin @(negedge ck); n++; end
    if (n >= 40) begin checks++; failures++; $display("FAIL full_reads timeout got=%0d required=2", in_rd_cnt[0] - r0); end
    for (int i = 0; i < 6; i++) begin
      @(negedge ck);
      checks++;
      if (gnt !== 2'b01 || out_wr !== 2'b00) begin
        failures++; $display("FAIL full_hold cycle=%0d got gnt=%b wr=%b required gnt=01 wr=00", i, gnt, out_wr);
      end
    end
    @(posedge ck); #1 out_full[0] = 1'b0;
    @(negedge ck);
    checks++; if (out_wr !== 2'b01) begin failures++; $display("FAIL full_release_wr got=%b required=01", out_wr); end
    wait_drain("out_full", 60);
  endtask

  task automatic test_in_toggle();
    int r1 = in_rd_cnt[1];
    bit seen = 0;
    bit fin = 0;
    int bad = 0;
    push_len(1, 4'd4);
    push_dat(1, 32'd3); push_dat(1, 32'd5); push_dat(1, 32'd7); push_dat(1, 32'd11);
    push_exp(1, 32'd26);
    for (int i = 0; i < 80 && !fin; i++) begin
      @(negedge ck);
      if (i % 2 == 0) stall[1] = ~stall[1];
      if (gnt == 2'b10) seen = 1;
      else if (seen) bad++;
      if (out_wr[1]) fin = 1;
    end
    stall[1] = 1'b0;
    wait_drain("in_toggle", 60);
    checks++; if (!fin) begin failures++; $display("FAIL toggle_write got=none required=one ch1 write"); end
    checks++; if (bad != 0) begin failures++; $display("FAIL toggle_gnt_held drops=%0d required=0", bad); end
    checks++; if (in_rd_cnt[1] - r1 != 4) begin failures++; $display("FAIL toggle_reads got=%0d required=4", in_rd_cnt[1] - r1); end
  endtask

  task automatic test_err();
    @(negedge ck);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_pre got=%b required=0", err); end
    force_in0_rd = 1'b1;
    @(negedge ck);
    force_in0_rd = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b required=1", err); end
    repeat (5) @(negedge ck);
    checks++; if (err !== 1'b1 || gnt !== 2'b00) begin
      failures++; $display("FAIL err_sticky got err=%b gnt=%b required err=1 gnt=00", err, gnt);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int d0;
    push_len(0, 4'd3);
    push_dat(0, 32'd1); push_dat(0, 32'd1); push_dat(0, 32'd1);
    while (n < 40 && !in_rd[0]) begin @(negedge ck); n++; end
    if (n >= 40) begin checks++; failures++; $display("FAIL midrst_start timeout got=no read required=read"); end
    #2 rst = 1'b0;
    #1;
    checks++; if (gnt !== 2'b00 || done !== 2'b00 || err !== 1'b0) begin
      failures++; $display("FAIL midrst_state got gnt=%b done=%b err=%b required 00 00 0", gnt, done, err);
    end
    checks++; if ({len_rd, in_rd, out_wr} !== 6'b0) begin
      failures++; $display("FAIL midrst_rdwr got=%b required=000000", {len_rd, in_rd, out_wr});
    end
    checks++; if ({acc_nda_empty, acc_in0_empty, acc_out0_full} !== 3'b111 || acc_nda_data !== 4'd0) begin
      failures++; $display("FAIL midrst_acc got=%b tok=%0d required=111 tok=0", {acc_nda_empty, acc_in0_empty, acc_out0_full}, acc_nda_data);
    end
    repeat (2) @(negedge ck);
    lenq0.delete(); lenq1.delete(); datq0.delete(); datq1.delete();
    obs_q.delete(); exp_q.delete();
    @(negedge ck);
    rst = 1'b1;
    repeat (2) @(negedge ck);
    d0 = done_cnt[0];
    push_len(0, 4'd1);
    push_dat(0, 32'd42);
    push_exp(0, 32'd42);
    wait_drain("post_reset", 60);
    checks++; if (done_cnt[0] - d0 != 1) begin failures++; $display("FAIL post_reset_done got=%0d required=1", done_cnt[0] - d0); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alternate();
    test_single();
    test_zero_len();
    test_out_full();
    test_in_toggle();
    checks++; if (viol != 0) begin failures++; $display("FAIL ungranted_activity got=%0d required=0", viol); end
    test_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddf_acc_arbiter_2ch.md
# ddf_acc_arbiter_2ch

Round-robin scheduler that shares one DDF accumulator actor (NDA-driven, one-producer/one-firing) between two requesting channels. Each channel supplies a burst-length FIFO and a data FIFO and owns an output FIFO. The block sits between the channel FIFOs and the actor's NDA/in0/out0 ports. It serialises whole bursts: token hand-off, data routing, result return.

## Interface
- WIDTH, 32, data width of channel and actor data paths
- WIDTH_NDA, 4, width of burst-length (NDA) tokens

- ck  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- chN_len_empty  in  1  channel N (N=0,1) length FIFO empty
- chN_len_data  in  WIDTH_NDA  channel N length token, first-word-fall-through (FWFT)
- chN_len_rd  out  1  pop channel N length FIFO
- chN_in_empty  in  1  channel N data FIFO empty
- chN_in_data  in  WIDTH  channel N data word, FWFT
- chN_in_rd  out  1  pop channel N data FIFO
- chN_out_full  in  1  channel N result FIFO full
- chN_out_wr  out  1  push channel N result FIFO
- chN_out_data  out  WIDTH  result word
- acc_nda_empty  out  1  to actor nda_empty
- acc_nda_data  out  WIDTH_NDA  to actor nda_data
- acc_nda_rd  in  1  from actor nda_rd
- acc_in0_empty  out  1  to actor in0_empty
- acc_in0_data  out  WIDTH  to actor in0_data
- acc_in0_rd  in  1  from actor in0_rd
- acc_out0_full  out  1  to actor out0_full
- acc_out0_wr  in  1  from actor out0_wr
- acc_out0_data  in  WIDTH  from actor out0_data
- gnt  out  2  one-hot current owner, 0 when idle
- done  out  2  one-cycle pulse per channel on burst completion
- err  out  1  sticky protocol-violation flag

## Operation
- FSM states:
  - IDLE: select a channel with len FIFO non-empty.
    - If both are non-empty, pick the channel not served last. The reset pointer favours ch0.
    - Pulse chN_len_rd for one cycle and latch chN_len_data into tok.
    - Latch per-burst read count rdc=0, set gnt, go to OFFER.
  - OFFER: acc_nda_empty=0 and acc_nda_data=tok.
    - On acc_nda_rd=1 with tok==0: pulse done[N], go to IDLE.
    - On acc_nda_rd=1 with tok!=0: go to BUSY.
  - BUSY: route the granted channel.
    - acc_in0_empty=chN_in_empty.
    - acc_in0_data=chN_in_data.
    - chN_in_rd=acc_in0_rd.
    - acc_out0_full=chN_out_full.
    - chN_out_wr=acc_out0_wr.
    - rdc increments on each acc_in0_rd.
    - On acc_out0_wr=1: pulse done[N], update the pointer, go to IDLE.
- Outside BUSY:
  - acc_in0_empty=1 and acc_out0_full=1.
  - All chN_in_rd and chN_out_wr are 0.
- Outside OFFER: acc_nda_empty=1.
- tok holds its value until the next IDLE latch. This keeps acc_nda_data stable during the actor's CHOICE cycle.
- chN_out_data=acc_out0_data for both channels. Only the granted chN_out_wr may assert.
- The ungranted channel's rd/wr are always 0.
- err is set, and held until reset, on any of:
  - acc_in0_rd or acc_out0_wr outside BUSY;
  - acc_nda_rd outside OFFER;
  - acc_in0_rd when rdc==tok (more reads than the burst length).
- Setting err does not alter FSM flow.
- rdc is WIDTH_NDA bits wide and cannot wrap while err is unset.

## Timing
- Reset values:
  - state=IDLE, gnt=0, done=0, err=0, tok=0, rdc=0, pointer=ch0-first.
  - All rd/wr outputs=0.
  - acc_nda_empty=1, acc_in0_empty=1, acc_out0_full=1.
- chN_len_rd is registered: it asserts the cycle after IDLE sees a non-empty FIFO, for exactly 1 cycle, together with gnt.
- Latency from IDLE with a pending token to acc_nda_empty=0 is 1 cycle.
- Idle gap between back-to-back bursts is 2 cycles: write edge, then IDLE, then OFFER.
- Data and result paths in BUSY are purely combinational, so there is no added latency in the actor's in0/out0 handshake.
- A full output FIFO holds BUSY indefinitely. The grant is never revoked mid-burst.
- A new token arriving during BUSY waits. A token arriving on the other channel on the same edge as done is evaluated in the following IDLE cycle.
- Reset mid-burst returns the block to IDLE immediately. The actor is reset by the same rst.

## Test plan
- ch0 len=3, data 1,2,3 → one ch0_out_wr with data 6; done[0] pulses once; ch1 rd/wr stay 0; err=0.
- ch0 and ch1 each hold two len=2 tokens, data all 1 → results alternate ch0,ch1,ch0,ch1, each =2; ≥2 idle cycles between grants.
- ch1 len=0 → ch1_len_rd pulse, acc_nda_rd accepted, done[1] pulses; no ch1_in_rd, no ch1_out_wr; next ch1 len=2 (data 5,7) gives 12.
- ch0 len=2 with ch0_out_full=1 for 6 cycles at burst end → gnt stays 2'b01, no write; write of the sum occurs in the cycle full drops.
- ch1 len=4 with ch1_in_empty toggling every 2 cycles → result correct; gnt held throughout; rdc ends at 4.
- Force acc_in0_rd=1 while IDLE → err=1 next cycle and held; assert rst mid-burst → all outputs return to reset values asynchronously.
